// File: rtl/sram_like_mem_model.sv
// SRAM-like slave memory for CPU benches: stallable accept, in-order responses after DATA_LATENCY, byte/half/word writes.
// Latency: data_ok exactly DATA_LATENCY cycles after acceptance when idle; addr_ok drops during stall or when MAX_OUTSTANDING are in flight.
module sram_like_mem_model #(
    parameter int DEPTH           = 65536,
    parameter int ADDR_STALL      = 0,
    parameter int DATA_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic        err,
    output logic        mon_wr_valid,
    output logic [31:0] mon_wr_addr,
    output logic [1:0]  mon_wr_size,
    output logic [31:0] mon_wr_data
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0]    LAT_M1     = 4'(DATA_LATENCY - 1);
    localparam logic [3:0]    STALL_INIT = 4'(ADDR_STALL);
    localparam logic [3:0]    MAX_CNT    = 4'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   mem [0:DEPTH-1];
    logic [31:0]   q_dat [MAX_OUTSTANDING];
    logic [3:0]    q_age [MAX_OUTSTANDING];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [3:0]    count, stall_cnt;
    logic          err_q;

    logic [IW-1:0] idx;
    logic [3:0]    be;
    logic          bad;
    logic          accept, do_write;
    logic [31:0]   push_dat;
    logic          unused_addr;

    assign idx         = addr[IW+1:2];
    assign unused_addr = ^addr[31:IW+2];

    always_comb begin
        be  = 4'b0000;
        bad = 1'b0;
        case (size)
            2'd0: be = 4'b0001 << addr[1:0];
            2'd1: begin
                be  = addr[1] ? 4'b1100 : 4'b0011;
                bad = addr[0];
            end
            2'd2: begin
                be  = 4'b1111;
                bad = (addr[1:0] != 2'b00);
            end
            default: bad = 1'b1;
        endcase
    end

    // A pop in the same cycle does not free a slot: addr_ok looks at count only.
    assign addr_ok  = !rst && (stall_cnt == 4'd0) && (count < MAX_CNT);
    assign accept   = req && addr_ok;
    assign do_write = accept && wr && !bad;
    assign push_dat = wr ? 32'd0 : mem[idx];

    // The head is always at least one cycle old, so it was never accepted this cycle.
    assign data_ok = !rst && (count != 4'd0) && (q_age[rd_ptr] >= LAT_M1);
    assign rdata   = data_ok ? q_dat[rd_ptr] : 32'd0;
    assign err     = err_q;

    assign mon_wr_valid = accept && wr;
    assign mon_wr_addr  = mon_wr_valid ? addr  : 32'd0;
    assign mon_wr_size  = mon_wr_valid ? size  : 2'd0;
    assign mon_wr_data  = mon_wr_valid ? wdata : 32'd0;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 4'd0;
            stall_cnt <= 4'd0;
            err_q     <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (q_age[i] != 4'd15)
                    q_age[i] <= q_age[i] + 4'd1;
            end
            if (accept) begin
                q_dat[wr_ptr] <= push_dat;
                q_age[wr_ptr] <= 4'd0;
                wr_ptr        <= next_ptr(wr_ptr);
                stall_cnt     <= STALL_INIT;
                if (bad)
                    err_q <= 1'b1;
            end else if (stall_cnt != 4'd0) begin
                stall_cnt <= stall_cnt - 4'd1;
            end
            if (data_ok)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + {3'd0, accept} - {3'd0, data_ok};
        end
    end

    // Memory is deliberately left out of reset so preloaded contents survive it.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (do_write && be[b])
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
endmodule
